// File: rtl/aes_trig_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : aes_trig_seq_gen
// Purpose  : Sends the four-word AES trigger activation sequence onto the AES
//            core's 128-bit plaintext input over a valid/ready handshake. The
//            sequence can repeat, and idle gaps can be placed between words.
//
// Parameters
//   GAP_CYCLES : idle cycles after each accepted word (0..255)
//   REPEAT     : full passes of the sequence per start (1..15)
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   start      in   1    begin a run (only acted on while idle)
//   abort      in   1    stop the current run at the next edge
//   pt_ready   in   1    AES input accepts pt_data this cycle
//   pt_valid   out  1    pt_data holds a sequence word
//   pt_data    out  128  plaintext word (all-ones when not valid)
//   seq_idx    out  2    index of the word being presented
//   busy       out  1    run in progress
//   done       out  1    one-cycle pulse on normal completion
//   pass_cnt   out  4    completed passes in the current or last run
//
// Build option
//   TRIG_SEQ_DECOY_EN : when defined, a decoy word is sent between W1 and W2
//                       in every pass (seq_idx reads 1 while it is shown).
//
// Revision : 1.0 - initial release
// ============================================================================
module aes_trig_seq_gen #(
    parameter int GAP_CYCLES = 0,
    parameter int REPEAT     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         pt_ready,
    output logic         pt_valid,
    output logic [127:0] pt_data,
    output logic [1:0]   seq_idx,
    output logic         busy,
    output logic         done,
    output logic [3:0]   pass_cnt
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;
    localparam logic [1:0] c_ST_FIN  = 2'd3;

    localparam logic [127:0] c_W0        = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] c_W1        = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] c_W2        = 128'h0;
    localparam logic [127:0] c_W3        = 128'h1;
    // Idle value is chosen so that it can never be mistaken for a sequence word.
    localparam logic [127:0] c_IDLE_DATA = {128{1'b1}};

    localparam logic [7:0] c_GAP_LOAD = 8'(GAP_CYCLES);
    localparam logic [4:0] c_REPEAT   = 5'(REPEAT);

    logic [1:0] state_q,    state_d;
    logic [1:0] seq_idx_q,  seq_idx_d;
    logic [3:0] pass_cnt_q, pass_cnt_d;
    logic [7:0] gap_cnt_q,  gap_cnt_d;

    logic w_advance;
    logic w_last_word;
    logic w_more_passes;

`ifdef TRIG_SEQ_DECOY_EN
    localparam logic [127:0] c_WD = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    // Set while the decoy is the current word; seq_idx stays at 1 meanwhile.
    logic decoy_q, decoy_d;
`endif

    // The decoy sits between indices 1 and 2, so index 3 is always the last word.
    assign w_last_word   = (seq_idx_q == 2'd3);
    assign w_more_passes = (({1'b0, pass_cnt_q} + 5'd1) < c_REPEAT);

    // Move to the next word: straight after a transfer when there is no gap,
    // otherwise on the final gap cycle. abort overrides either.
    always_comb begin
        w_advance = 1'b0;
        if (!abort) begin
            if (state_q == c_ST_SEND) begin
                w_advance = pt_ready && (c_GAP_LOAD == 8'd0);
            end else if (state_q == c_ST_GAP) begin
                w_advance = (gap_cnt_q == 8'd1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_ST_IDLE;
            seq_idx_q  <= 2'd0;
            pass_cnt_q <= 4'd0;
            gap_cnt_q  <= 8'd0;
`ifdef TRIG_SEQ_DECOY_EN
            decoy_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            seq_idx_q  <= seq_idx_d;
            pass_cnt_q <= pass_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef TRIG_SEQ_DECOY_EN
            decoy_q    <= decoy_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        seq_idx_d  = seq_idx_q;
        pass_cnt_d = pass_cnt_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef TRIG_SEQ_DECOY_EN
        decoy_d    = decoy_q;
`endif

        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    state_d    = c_ST_SEND;
                    seq_idx_d  = 2'd0;
                    pass_cnt_d = 4'd0;
                    gap_cnt_d  = 8'd0;
`ifdef TRIG_SEQ_DECOY_EN
                    decoy_d    = 1'b0;
`endif
                end
            end
            c_ST_SEND: begin
                if (abort) begin
                    state_d = c_ST_IDLE;
`ifdef TRIG_SEQ_DECOY_EN
                    decoy_d = 1'b0;
`endif
                    // The core took this word, so a final word still closes the pass.
                    if (pt_ready && w_last_word) begin
                        pass_cnt_d = pass_cnt_q + 4'd1;
                    end
                end else if (pt_ready && (c_GAP_LOAD != 8'd0)) begin
                    state_d   = c_ST_GAP;
                    gap_cnt_d = c_GAP_LOAD;
                end
            end
            c_ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (abort) begin
                    state_d   = c_ST_IDLE;
                    gap_cnt_d = 8'd0;
`ifdef TRIG_SEQ_DECOY_EN
                    decoy_d   = 1'b0;
`endif
                end
            end
            c_ST_FIN: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase

        if (w_advance) begin
`ifdef TRIG_SEQ_DECOY_EN
            if ((seq_idx_q == 2'd1) && !decoy_q) begin
                decoy_d = 1'b1;
                state_d = c_ST_SEND;
            end else if (decoy_q) begin
                decoy_d   = 1'b0;
                seq_idx_d = 2'd2;
                state_d   = c_ST_SEND;
            end else
`endif
            if (!w_last_word) begin
                seq_idx_d = seq_idx_q + 2'd1;
                state_d   = c_ST_SEND;
            end else begin
                pass_cnt_d = pass_cnt_q + 4'd1;
                if (w_more_passes) begin
                    seq_idx_d = 2'd0;
                    state_d   = c_ST_SEND;
                end else begin
                    state_d   = c_ST_FIN;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output logic (Moore: depends on registered state only)
    // ------------------------------------------------------------------------
    always_comb begin
        pt_valid = (state_q == c_ST_SEND);
        busy     = (state_q == c_ST_SEND) || (state_q == c_ST_GAP);
        done     = (state_q == c_ST_FIN);
        seq_idx  = seq_idx_q;
        pass_cnt = pass_cnt_q;
        pt_data  = c_IDLE_DATA;
        if (state_q == c_ST_SEND) begin
            case (seq_idx_q)
                2'd0:    pt_data = c_W0;
                2'd1:    pt_data = c_W1;
                2'd2:    pt_data = c_W2;
                default: pt_data = c_W3;
            endcase
`ifdef TRIG_SEQ_DECOY_EN
            if (decoy_q) begin
                pt_data = c_WD;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_trig_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_trig_seq_gen
// Purpose  : Self-checking bench for aes_trig_seq_gen. Two instances are
//            used: inst0 (GAP_CYCLES=0, REPEAT=1) and inst1 (GAP_CYCLES=2,
//            REPEAT=2). A transfer-level model tracks each run as a linear
//            word position plus a gap countdown and is checked against the
//            outputs every cycle. Directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_trig_seq_gen;

`ifdef TRIG_SEQ_DECOY_EN
    localparam int N_WORDS = 5;
`else
    localparam int N_WORDS = 4;
`endif
    localparam int GAP0 = 0;
    localparam int REP0 = 1;
    localparam int GAP1 = 2;
    localparam int REP1 = 2;

    localparam logic [127:0] c_W0   = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] c_W1   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] c_ONES = {128{1'b1}};

    logic         clk;
    logic         rst_v    [2];
    logic         start_v  [2];
    logic         abort_v  [2];
    logic         ready_v  [2];
    logic         valid_o  [2];
    logic [127:0] data_o   [2];
    logic [1:0]   idx_o    [2];
    logic         busy_o   [2];
    logic         done_o   [2];
    logic [3:0]   pc_o     [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: a run is a list of words at linear positions m_pos.
    logic [127:0] m_words [5];
    logic [1:0]   m_idx   [5];
    int m_known  [2];
    int m_run    [2];
    int m_fin    [2];
    int m_pos    [2];
    int m_gap    [2];
    int m_passes [2];
    int n_xfer   [2];
    int n_done   [2];

    aes_trig_seq_gen #(.GAP_CYCLES(GAP0), .REPEAT(REP0)) u_dut0 (
        .clk      (clk),
        .rst      (rst_v[0]),
        .start    (start_v[0]),
        .abort    (abort_v[0]),
        .pt_ready (ready_v[0]),
        .pt_valid (valid_o[0]),
        .pt_data  (data_o[0]),
        .seq_idx  (idx_o[0]),
        .busy     (busy_o[0]),
        .done     (done_o[0]),
        .pass_cnt (pc_o[0])
    );

    aes_trig_seq_gen #(.GAP_CYCLES(GAP1), .REPEAT(REP1)) u_dut1 (
        .clk      (clk),
        .rst      (rst_v[1]),
        .start    (start_v[1]),
        .abort    (abort_v[1]),
        .pt_ready (ready_v[1]),
        .pt_valid (valid_o[1]),
        .pt_data  (data_o[1]),
        .seq_idx  (idx_o[1]),
        .busy     (busy_o[1]),
        .done     (done_o[1]),
        .pass_cnt (pc_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // End of a gap-free transfer or of a gap: close the pass if the word was the last.
    task automatic pass_boundary(input int i);
        int rep;
        rep = (i == 0) ? REP0 : REP1;
        if ((m_pos[i] % N_WORDS) == 0) begin
            m_passes[i]++;
            if (m_passes[i] == rep) begin
                m_run[i] = 0;
                m_fin[i] = 1;
            end
        end
    endtask

    // Apply the rules for one rising edge using the inputs that edge samples.
    task automatic model_advance(input int i);
        int g;
        g = (i == 0) ? GAP0 : GAP1;
        if (rst_v[i]) begin
            m_known[i]  = 1;
            m_run[i]    = 0;
            m_fin[i]    = 0;
            m_pos[i]    = 0;
            m_gap[i]    = 0;
            m_passes[i] = 0;
        end else if (m_fin[i] != 0) begin
            m_fin[i] = 0;
        end else if (m_run[i] == 0) begin
            if (start_v[i]) begin
                m_run[i]    = 1;
                m_pos[i]    = 0;
                m_passes[i] = 0;
                m_gap[i]    = 0;
            end
        end else if (m_gap[i] == 0) begin
            if (ready_v[i]) begin
                m_pos[i]++;
                if (abort_v[i]) begin
                    if ((m_pos[i] % N_WORDS) == 0) m_passes[i]++;
                    m_run[i] = 0;
                end else if (g > 0) begin
                    m_gap[i] = g;
                end else begin
                    pass_boundary(i);
                end
            end else if (abort_v[i]) begin
                m_run[i] = 0;
            end
        end else if (abort_v[i]) begin
            m_run[i] = 0;
            m_gap[i] = 0;
        end else begin
            m_gap[i]--;
            if (m_gap[i] == 0) pass_boundary(i);
        end
    endtask

    task automatic model_compare(input int i);
        logic         ev;
        logic [127:0] ew;
        if (m_known[i] == 0) return;
        ev = (m_run[i] != 0) && (m_gap[i] == 0);
        ew = ev ? m_words[m_pos[i] % N_WORDS] : c_ONES;
        chk($sformatf("inst%0d pt_valid", i), 128'(valid_o[i]), 128'(ev));
        chk($sformatf("inst%0d pt_data", i), data_o[i], ew);
        chk($sformatf("inst%0d busy", i), 128'(busy_o[i]), 128'(m_run[i] != 0));
        chk($sformatf("inst%0d done", i), 128'(done_o[i]), 128'(m_fin[i] != 0));
        chk($sformatf("inst%0d pass_cnt", i), 128'(pc_o[i]), 128'(m_passes[i]));
        if (ev) begin
            chk($sformatf("inst%0d seq_idx", i), 128'(idx_o[i]), 128'(m_idx[m_pos[i] % N_WORDS]));
        end
    endtask

    // Compare on the falling edge, then step the model for the next rising edge.
    initial begin
        m_words[0] = c_W0;
        m_words[1] = c_W1;
`ifdef TRIG_SEQ_DECOY_EN
        m_words[2] = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        m_words[3] = 128'h0;
        m_words[4] = 128'h1;
        m_idx[0] = 2'd0; m_idx[1] = 2'd1; m_idx[2] = 2'd1; m_idx[3] = 2'd2; m_idx[4] = 2'd3;
`else
        m_words[2] = 128'h0;
        m_words[3] = 128'h1;
        m_words[4] = 128'h0;
        m_idx[0] = 2'd0; m_idx[1] = 2'd1; m_idx[2] = 2'd2; m_idx[3] = 2'd3; m_idx[4] = 2'd0;
`endif
        for (int i = 0; i < 2; i++) begin
            m_known[i] = 0; m_run[i] = 0; m_fin[i] = 0; m_pos[i] = 0;
            m_gap[i] = 0; m_passes[i] = 0; n_xfer[i] = 0; n_done[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                model_compare(i);
                if (m_known[i] != 0) begin
                    if (valid_o[i] && ready_v[i]) n_xfer[i]++;
                    if (done_o[i] === 1'b1) n_done[i]++;
                end
                model_advance(i);
            end
        end
    end

    // Inputs only change 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while ((busy_o[i] || done_o[i]) && (n < budget)) begin
            step();
            n++;
        end
        chk($sformatf("inst%0d run ends within budget", i), 128'(busy_o[i] || done_o[i]), 128'(0));
    endtask

    task automatic chk_reset_vals(input int i);
        chk($sformatf("inst%0d reset pt_valid", i), 128'(valid_o[i]), 128'(0));
        chk($sformatf("inst%0d reset pt_data", i), data_o[i], c_ONES);
        chk($sformatf("inst%0d reset seq_idx", i), 128'(idx_o[i]), 128'(0));
        chk($sformatf("inst%0d reset busy", i), 128'(busy_o[i]), 128'(0));
        chk($sformatf("inst%0d reset done", i), 128'(done_o[i]), 128'(0));
        chk($sformatf("inst%0d reset pass_cnt", i), 128'(pc_o[i]), 128'(0));
    endtask

    initial begin
        int x0;
        int d0;
        int n;
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; abort_v[i] = 1'b0; ready_v[i] = 1'b0;
        end
        step();
        step();
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        @(negedge clk);
        chk_reset_vals(0);
        chk_reset_vals(1);

        // A: no gap, ready held high (ready while idle must do nothing).
        step();
        ready_v[0] = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("inst0 idle with ready high", 128'(busy_o[0]), 128'(0));
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        for (int k = 0; k < N_WORDS; k++) begin
            @(negedge clk);
            chk("A word valid", 128'(valid_o[0]), 128'(1));
            if (k == 0) chk("A first word W0", data_o[0], c_W0);
            if (k == 1) chk("A second word W1", data_o[0], c_W1);
            if (k == N_WORDS - 1) chk("A last word seq_idx", 128'(idx_o[0]), 128'(3));
            step();
        end
        @(negedge clk);
        chk("A done pulse", 128'(done_o[0]), 128'(1));
        chk("A busy low at done", 128'(busy_o[0]), 128'(0));
        chk("A pass_cnt final", 128'(pc_o[0]), 128'(1));
        step();
        @(negedge clk);
        chk("A done one cycle only", 128'(done_o[0]), 128'(0));
        chk("A pass_cnt held", 128'(pc_o[0]), 128'(1));
        step();

        // B: stall with W1 presented.
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        step();
        ready_v[0] = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("B stall pt_valid", 128'(valid_o[0]), 128'(1));
        chk("B stall pt_data W1", data_o[0], c_W1);
        chk("B stall seq_idx", 128'(idx_o[0]), 128'(1));
        step();
        ready_v[0] = 1'b1;
        step();
        @(negedge clk);
        chk("B word after stall", data_o[0], m_words[2]);
        wait_idle(0, 50);
        step();

        // C: gap 2, repeat 2.
        x0 = n_xfer[1];
        d0 = n_done[1];
        ready_v[1] = 1'b1;
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        step();
        @(negedge clk);
        chk("C gap after W0 pt_valid", 128'(valid_o[1]), 128'(0));
        chk("C gap after W0 pt_data", data_o[1], c_ONES);
        wait_idle(1, 200);
        chk("C transfer count", 128'(n_xfer[1] - x0), 128'(2 * N_WORDS));
        chk("C done pulse count", 128'(n_done[1] - d0), 128'(1));
        chk("C pass_cnt final", 128'(pc_o[1]), 128'(2));

        // D: abort while W2 presented and ready low.
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        step();
        step();
        ready_v[0] = 1'b0;
        abort_v[0] = 1'b1;
        step();
        abort_v[0] = 1'b0;
        @(negedge clk);
        chk("D abort pt_valid", 128'(valid_o[0]), 128'(0));
        chk("D abort busy", 128'(busy_o[0]), 128'(0));
        chk("D abort no done", 128'(done_o[0]), 128'(0));
        chk("D abort pass_cnt", 128'(pc_o[0]), 128'(0));
        step();
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("D restart at W0", data_o[0], c_W0);
        step();
        ready_v[0] = 1'b1;
        wait_idle(0, 50);

        // E: start while busy is ignored; reset during a gap of pass 2.
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        step();
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        n = 0;
        while (!((pc_o[1] == 4'd1) && busy_o[1] && !valid_o[1]) && (n < 100)) begin
            step();
            n++;
        end
        chk("E reached pass-2 gap", 128'(n < 100), 128'(1));
        rst_v[1] = 1'b1;
        step();
        rst_v[1] = 1'b0;
        @(negedge clk);
        chk_reset_vals(1);
        step();

        // F: start and abort together in idle -> start wins; abort with a transfer.
        ready_v[0] = 1'b0;
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        @(negedge clk);
        chk("F start beats abort", 128'(valid_o[0]), 128'(1));
        step();
        ready_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        step();
        ready_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        @(negedge clk);
        chk("F abort with transfer busy", 128'(busy_o[0]), 128'(0));
        chk("F abort with transfer done", 128'(done_o[0]), 128'(0));
        for (int k = 0; k < 4; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (compared %0d)", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
